multi_interval_timer: RTL and testbench



---
 rtl/multi_interval_timer.sv | 192 +++++++++++++++++++
 tb/tb_multi_interval_timer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_interval_timer.sv
// NUM_CH-channel interval timer with per-channel Avalon-MM register bank, PWM compare output and OR-ed IRQ.
// Build option: define TIMER_PWM_EN to implement the CMP registers and the pwm_out compare logic.
package mit_pkg;
  typedef struct packed {
    logic        we;
    logic [2:0]  idx;
    logic [15:0] wdata;
  } mit_req_t;

  typedef struct packed {
    logic [15:0] rdata;
    logic        irq;
    logic        pwm;
  } mit_rsp_t;
endpackage

module mit_channel
  import mit_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 99999
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  mit_req_t req_i,
  output mit_rsp_t rsp_o
);
  localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(DEFAULT_PERIOD);

  logic [CNT_W-1:0] cnt_q, cnt_d, per_q, per_d, snap_q, snap_d, cmp_val;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             to_q, to_d, run_q, run_d, force_q, force_d, nz_q;
  logic             wr_st, wr_ctl, wr_per, wr_snap, cnt_zero, tmo, pwm;
  logic [15:0]      rdata;

  assign wr_st    = req_i.we && (req_i.idx == 3'd0);
  assign wr_ctl   = req_i.we && (req_i.idx == 3'd1);
  assign wr_per   = req_i.we && (req_i.idx[2:1] == 2'b01);
  assign wr_snap  = req_i.we && (req_i.idx[2:1] == 2'b10);
  assign cnt_zero = (cnt_q == '0);
  // count just arrived at zero; holding at zero does not retrigger
  assign tmo      = cnt_zero && nz_q;

  always_comb begin
    cnt_d   = cnt_q;
    per_d   = per_q;
    snap_d  = snap_q;
    ctrl_d  = ctrl_q;
    run_d   = run_q;
    to_d    = to_q;
    force_d = wr_per;
    if (wr_per)
      per_d = req_i.idx[0] ? CNT_W'({req_i.wdata, per_q[15:0]})
                           : {per_q[CNT_W-1:16], req_i.wdata};
    if (wr_snap) snap_d = cnt_q;
    if (wr_ctl)  ctrl_d = req_i.wdata[3:0];
    if (force_q) begin
      cnt_d = per_q;
      run_d = 1'b0;
    end else begin
      if (run_q) begin
        if (!cnt_zero)     cnt_d = cnt_q - CNT_W'(1);
        else if (ctrl_q[1]) cnt_d = per_q;
        else               run_d = 1'b0;
      end
      if (wr_ctl && req_i.wdata[2])      run_d = 1'b1;
      else if (wr_ctl && req_i.wdata[3]) run_d = 1'b0;
    end
    if (tmo)        to_d = 1'b1;
    else if (wr_st) to_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= RST_VAL;
      per_q   <= RST_VAL;
      snap_q  <= '0;
      ctrl_q  <= '0;
      to_q    <= 1'b0;
      run_q   <= 1'b0;
      force_q <= 1'b0;
      nz_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      snap_q  <= snap_d;
      ctrl_q  <= ctrl_d;
      to_q    <= to_d;
      run_q   <= run_d;
      force_q <= force_d;
      nz_q    <= ~cnt_zero;
    end
  end

`ifdef TIMER_PWM_EN
  logic [CNT_W-1:0] cmp_q, cmp_d;

  always_comb begin
    cmp_d = cmp_q;
    if (req_i.we && req_i.idx == 3'd6) cmp_d = {cmp_q[CNT_W-1:16], req_i.wdata};
    if (req_i.we && req_i.idx == 3'd7) cmp_d = CNT_W'({req_i.wdata, cmp_q[15:0]});
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cmp_q <= '0;
    else       cmp_q <= cmp_d;
  end

  assign cmp_val = cmp_q;
  assign pwm     = run_q && (cnt_q < cmp_q);
`else
  assign cmp_val = '0;
  assign pwm     = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    case (req_i.idx)
      3'd0:    rdata = {14'd0, run_q, to_q};
      3'd1:    rdata = {12'd0, ctrl_q};
      3'd2:    rdata = per_q[15:0];
      3'd3:    rdata = 16'(per_q >> 16);
      3'd4:    rdata = snap_q[15:0];
      3'd5:    rdata = 16'(snap_q >> 16);
      3'd6:    rdata = cmp_val[15:0];
      default: rdata = 16'(cmp_val >> 16);
    endcase
  end

  assign rsp_o = '{rdata: rdata, irq: to_q & ctrl_q[0], pwm: pwm};
endmodule

module multi_interval_timer
  import mit_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 99999
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [$clog2(NUM_CH)+2:0] address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [15:0]               writedata,
  output logic [15:0]               readdata,
  output logic                      irq,
  output logic [NUM_CH-1:0]         pwm_out
);
  localparam int AW = $clog2(NUM_CH) + 3;

  logic [AW-1:0]             ch_sel;
  mit_rsp_t [NUM_CH-1:0]     rsp;
  logic [NUM_CH-1:0]         ch_irq;
  logic [15:0]               rd_mux, rd_q, rd_d;

  // channel numbers beyond NUM_CH match no instance, so they read 0 and drop writes
  assign ch_sel = address >> 3;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mit_req_t req;
    assign req.we    = chipselect && !write_n && (ch_sel == AW'(i));
    assign req.idx   = address[2:0];
    assign req.wdata = writedata;

    mit_channel #(.CNT_W(CNT_W), .DEFAULT_PERIOD(DEFAULT_PERIOD)) u_ch (
      .clk_i (clk),
      .rst_i (reset),
      .req_i (req),
      .rsp_o (rsp[i])
    );

    assign ch_irq[i]  = rsp[i].irq;
    assign pwm_out[i] = rsp[i].pwm;
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_sel == AW'(i)) rd_mux = rsp[i].rdata;
  end

  assign rd_d = (chipselect && write_n) ? rd_mux : rd_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_q <= '0;
    else       rd_q <= rd_d;
  end

  assign readdata = rd_q;
  assign irq      = |ch_irq;
endmodule

// File: tb/tb_multi_interval_timer.sv
// Directed bench for multi_interval_timer: a cycle-level register/timer model checked every clock,
// plus literal expectations from the test plan (reset values, timeout spacing, snapshot, collision).
module tb_multi_interval_timer;
  localparam int NUM_CH = 4;
  localparam int AW     = 5;
`ifdef TIMER_PWM_EN
  localparam bit PWM = 1'b1;
`else
  localparam bit PWM = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [AW-1:0]     address = '0;
  logic [15:0]       writedata = '0;
  logic [15:0]       readdata;
  logic              irq;
  logic [NUM_CH-1:0] pwm_out;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  multi_interval_timer #(.NUM_CH(NUM_CH), .CNT_W(32), .DEFAULT_PERIOD(99999)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .pwm_out    (pwm_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_cnt[NUM_CH], m_per[NUM_CH], m_cmp[NUM_CH], m_snap[NUM_CH];
  logic [3:0]  m_ctrl[NUM_CH];
  bit          m_to[NUM_CH], m_run[NUM_CH], m_reload_pending[NUM_CH], m_was_nonzero[NUM_CH];
  logic [15:0] m_rd;

  function automatic logic [15:0] reg_val(input int c, input int r);
    case (r)
      0: return {14'd0, m_run[c], m_to[c]};
      1: return {12'd0, m_ctrl[c]};
      2: return m_per[c][15:0];
      3: return m_per[c][31:16];
      4: return m_snap[c][15:0];
      5: return m_snap[c][31:16];
      6: return PWM ? m_cmp[c][15:0] : 16'd0;
      default: return PWM ? m_cmp[c][31:16] : 16'd0;
    endcase
  endfunction

  task automatic m_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_cnt[c] = 32'd99999; m_per[c] = 32'd99999; m_cmp[c] = 0; m_snap[c] = 0;
      m_ctrl[c] = 0; m_to[c] = 0; m_run[c] = 0; m_reload_pending[c] = 0; m_was_nonzero[c] = 0;
    end
    m_rd = 0;
  endtask

  task automatic m_step();
    int ch = int'(address >> 3);
    int r  = int'(address[2:0]);
    if (chipselect && write_n) m_rd = (ch < NUM_CH) ? reg_val(ch, r) : 16'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      bit w       = chipselect && !write_n && (ch == c);
      bit start   = w && (r == 1) && writedata[2];
      bit stop    = w && (r == 1) && writedata[3] && !writedata[2];
      logic [31:0] now = m_cnt[c];
      bit at_zero = (now == 0);
      bit oneshot_end = m_run[c] && at_zero && !m_ctrl[c][1];
      // counter: pending reload first, else run rules (zero reloads or holds in one-shot)
      if (m_reload_pending[c])   m_cnt[c] = m_per[c];
      else if (m_run[c] && !at_zero) m_cnt[c] = now - 1;
      else if (m_run[c] && m_ctrl[c][1]) m_cnt[c] = m_per[c];
      // RUN: reload always clears; start beats stop
      if (m_reload_pending[c])            m_run[c] = 0;
      else if (start)                     m_run[c] = 1;
      else if (stop || oneshot_end)       m_run[c] = 0;
      if (at_zero && m_was_nonzero[c])    m_to[c] = 1;
      else if (w && r == 0)               m_to[c] = 0;
      m_was_nonzero[c]    = !at_zero;
      m_reload_pending[c] = w && (r == 2 || r == 3);
      if (w && r == 1) m_ctrl[c] = writedata[3:0];
      if (w && r == 2) m_per[c][15:0]  = writedata;
      if (w && r == 3) m_per[c][31:16] = writedata;
      if (w && (r == 4 || r == 5)) m_snap[c] = now;
      if (w && r == 6) m_cmp[c][15:0]  = writedata;
      if (w && r == 7) m_cmp[c][31:16] = writedata;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) m_reset();
    else       m_step();
  end

  function automatic logic exp_irq();
    logic x = 1'b0;
    for (int c = 0; c < NUM_CH; c++) x = x | (m_to[c] & m_ctrl[c][0]);
    return x;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_pwm();
    logic [NUM_CH-1:0] v = '0;
    for (int c = 0; c < NUM_CH; c++) v[c] = PWM && m_run[c] && (m_cnt[c] < m_cmp[c]);
    return v;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      check("irq", irq, exp_irq());
      check("pwm_out", pwm_out, exp_pwm());
      check("readdata", readdata, m_rd);
    end
  end

  // ---------------- bus tasks ----------------
  task automatic wr(input int a, input logic [15:0] d);
    address = AW'(a); writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input int a, input logic [15:0] mask, input logic [15:0] exp, input string name);
    address = AW'(a); chipselect = 1'b1; write_n = 1'b1;
    @(posedge clk); #1;
    chipselect = 1'b0;
    check(name, readdata & mask, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_irq(input int budget, output int t);
    int k = 0;
    while (!irq && k < budget) begin @(posedge clk); #1; k++; end
    check("irq_within_budget", irq, 1);
    t = cyc;
  endtask

  task automatic count_pwm0(input int n, output int hi);
    hi = 0;
    repeat (n) begin @(posedge clk); #1; if (pwm_out[0]) hi++; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int t0, t1, t2, hi;
    idle(3);
    reset = 1'b0;
    check("rst_irq", irq, 0);
    check("rst_pwm", pwm_out, 0);
    rd(2, 16'hFFFF, 16'h869F, "rst_per_l");
    rd(3, 16'hFFFF, 16'h0001, "rst_per_h");
    rd(1, 16'hFFFF, 16'h0000, "rst_ctrl");

    // continuous run, ch1 period 9
    wr(10, 9); wr(11, 0); idle(1);
    wr(9, 16'h7); t0 = cyc;
    wait_irq(40, t1);
    check("cont_first_to", t1 - t0, 10);
    wr(8, 0);
    check("irq_clear", irq, 0);
    wait_irq(40, t2);
    check("cont_spacing", t2 - t1, 10);
    wr(9, 16'h8); wr(8, 0);

    // one-shot, ch2 period 4
    wr(18, 4); wr(19, 0); idle(1);
    wr(17, 16'h5); t0 = cyc;
    wait_irq(40, t1);
    check("oneshot_to", t1 - t0, 5);
    idle(2);
    rd(16, 16'hFFFF, 16'h0001, "oneshot_status");
    wr(20, 0);
    rd(20, 16'hFFFF, 16'h0000, "oneshot_hold_l");
    rd(21, 16'hFFFF, 16'h0000, "oneshot_hold_h");
    wr(16, 0); wr(17, 0);

    // PWM, ch0 period 19
    wr(2, 19); wr(3, 0); wr(6, 5); wr(7, 0); idle(1);
    wr(1, 16'h6);
    count_pwm0(40, hi);
    check("pwm_cmp5", hi, PWM ? 10 : 0);
    wr(6, 0);
    count_pwm0(40, hi);
    check("pwm_cmp0", hi, 0);
    wr(6, 25);
    count_pwm0(40, hi);
    check("pwm_cmp25", hi, PWM ? 40 : 0);
    wr(1, 16'h8);

    // snapshot and reload while running, ch3 period 0x2FFFF
    wr(26, 16'hFFFF); wr(27, 16'h0002); idle(1);
    wr(25, 16'h6);
    idle(7);
    wr(28, 0);
    rd(28, 16'hFFFF, 16'hFFF8, "snap_l");
    rd(29, 16'hFFFF, 16'h0002, "snap_h");
    wr(26, 16'h0100);
    rd(24, 16'hFFFF, 16'h0002, "reload_run_still");
    rd(24, 16'hFFFF, 16'h0000, "reload_run_clr");
    wr(28, 0);
    rd(28, 16'hFFFF, 16'h0100, "reload_cnt_l");
    rd(29, 16'hFFFF, 16'h0002, "reload_cnt_h");

    // collision: STATUS write on the timeout edge, ch3 period 4
    wr(27, 0); wr(26, 4); idle(1);
    wr(25, 16'h7);
    idle(4);
    wr(24, 0);
    check("collision_irq", irq, 1);
    rd(24, 16'hFFFF, 16'h0003, "collision_status");
    wr(25, 16'h8);
    rd(24, 16'h0002, 16'h0000, "stop_run");
    wr(25, 16'hC);
    rd(24, 16'h0002, 16'h0002, "start_stop_run");
    rd(25, 16'hFFFF, 16'h000C, "start_stop_ctrl");

    // asynchronous reset mid-count
    wr(25, 16'h7);
    wr(1, 16'h6);
    check("pre_rst_irq", irq, 1);
    check("pre_rst_pwm", pwm_out[0], PWM);
    idle(2);
    #2 reset = 1'b1;
    #1;
    check("async_rst_irq", irq, 0);
    check("async_rst_pwm", pwm_out, 0);
    check("async_rst_rd", readdata, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    rd(24, 16'hFFFF, 16'h0000, "post_rst_status");
    rd(26, 16'hFFFF, 16'h869F, "post_rst_per_l");
    rd(25, 16'hFFFF, 16'h0000, "post_rst_ctrl");
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
